// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding
// and the default baud divisor.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } sched_state_e;

    localparam int CLK_DIV_DEFAULT = 434;

endpackage : uart_tx_sched_pkg

// File: rtl/uart_baud_div.sv
// Free-running baud divider: one-cycle clk_en when the count reaches CLK_DIV-1.
module uart_baud_div
    import uart_tx_sched_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic resetN,
    output logic clk_en
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;
    logic          tick_d;

    // Next count and a tick registered in step with the count it flags.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == CW'(CLK_DIV - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        tick_d = (cnt_d == CW'(CLK_DIV - 1));
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign clk_en = tick_q;

endmodule : uart_baud_div

// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler sharing one UART transmitter among NUM_REQ
// requesters. Define UART_TX_SCHED_PRIO_EN to give requester 0 fixed priority.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic [NUM_REQ-1:0]         reqValid,
    input  logic [8*NUM_REQ-1:0]       reqData,
    output logic [NUM_REQ-1:0]         reqReady,
    output logic [NUM_REQ-1:0]         reqDone,
    output logic                       txEnable,
    output logic [7:0]                 txData,
    output logic                       txClkEn,
    input  logic                       txBusy,
    output logic [$clog2(NUM_REQ)-1:0] grantIdx
);

    localparam int IW = $clog2(NUM_REQ);

    sched_state_e       state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [7:0]         data_q, data_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               en_q, en_d;

    logic               found_s;
    logic [IW-1:0]      win_s;
    logic [7:0]         win_data_s;

    uart_baud_div #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_div (
        .clk    (clk),
        .resetN (resetN),
        .clk_en (txClkEn)
    );

    // Winner search: first valid requester after the pointer, wrapping.
    always_comb begin
        int idx;
        found_s    = 1'b0;
        win_s      = '0;
        win_data_s = 8'h00;
        idx        = 0;
`ifdef UART_TX_SCHED_PRIO_EN
        if (reqValid[0]) begin
            found_s    = 1'b1;
            win_data_s = reqData[7:0];
        end else begin
            for (int k = 1; k < NUM_REQ; k++) begin
                idx = 1 + ((int'(ptr_q) - 1 + k) % (NUM_REQ - 1));
                if (!found_s && reqValid[idx]) begin
                    found_s    = 1'b1;
                    win_s      = IW'(idx);
                    win_data_s = reqData[8*idx +: 8];
                end else begin
                    found_s    = found_s;
                end
            end
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found_s && reqValid[idx]) begin
                found_s    = 1'b1;
                win_s      = IW'(idx);
                win_data_s = reqData[8*idx +: 8];
            end else begin
                found_s    = found_s;
            end
        end
`endif
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        ready_d = '0;
        done_d  = '0;
        en_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found_s && !txBusy) begin
                    data_d  = win_data_s;
                    grant_d = win_s;
                    ready_d = NUM_REQ'(1) << win_s;
                    en_d    = 1'b1;
                    state_d = WAIT_BUSY;
`ifdef UART_TX_SCHED_PRIO_EN
                    // Requester 0 bypasses the rotation, so it never moves the pointer.
                    if (win_s != '0) begin
                        ptr_d = win_s;
                    end else begin
                        ptr_d = ptr_q;
                    end
`else
                    ptr_d   = win_s;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (txBusy) begin
                    state_d = WAIT_DONE;
                end else begin
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (!txBusy) begin
                    done_d  = NUM_REQ'(1) << grant_q;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scheduler state and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NUM_REQ - 1);
            grant_q <= '0;
            data_q  <= 8'h00;
            ready_q <= '0;
            done_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            en_q    <= en_d;
        end
    end

    assign reqReady = ready_q;
    assign reqDone  = done_q;
    assign txEnable = en_q;
    assign txData   = data_q;
    assign grantIdx = grant_q;

endmodule : uart_tx_sched

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched (NUM_REQ=4, CLK_DIV=4), default build.
module tb_uart_tx_sched;

    logic        clk;
    logic        resetN;
    logic [3:0]  reqValid;
    logic [31:0] reqData;
    logic [3:0]  reqReady;
    logic [3:0]  reqDone;
    logic        txEnable;
    logic [7:0]  txData;
    logic        txClkEn;
    logic        txBusy;
    logic [1:0]  grantIdx;

    int checks;
    int errors;

    uart_tx_sched #(
        .NUM_REQ (4),
        .CLK_DIV (4)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .reqValid (reqValid),
        .reqData  (reqData),
        .reqReady (reqReady),
        .reqDone  (reqDone),
        .txEnable (txEnable),
        .txData   (txData),
        .txClkEn  (txClkEn),
        .txBusy   (txBusy),
        .grantIdx (grantIdx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic       busy;
        logic [3:0] ready;
        logic [3:0] done;
        logic       en;
        logic [1:0] grant;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transaction expected to be granted to exp_idx.
    task automatic do_txn(input int exp_idx, input string tag);
        int t;
        t = 0;
        while (txEnable !== 1'b1 && t < 10) begin
            cycle();
            t++;
        end
        check({tag, "_en"}, 32'(txEnable), 32'd1);
        check({tag, "_grant"}, 32'(grantIdx), 32'(exp_idx));
        check({tag, "_ready"}, 32'(reqReady), 32'd1 << exp_idx);
        txBusy = 1'b1;
        repeat (3) cycle();
        txBusy = 1'b0;
        t = 0;
        while (reqDone === 4'b0000 && t < 10) begin
            cycle();
            t++;
        end
        check({tag, "_done"}, 32'(reqDone), 32'd1 << exp_idx);
    endtask

    initial begin
        int en_k;
        int ready_cnt;
        int done_cnt;
        int done_k;
        int data_bad;
        logic [3:0] done_seen;

        checks = 0;
        errors = 0;

        // Fairness table, all requesters valid; each grant spans four rows.
        vecs[0]  = '{4'hF, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00};
        vecs[1]  = '{4'hF, 1'b0, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'h11};
        vecs[2]  = '{4'hF, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h11};
        vecs[3]  = '{4'hF, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h11};
        vecs[4]  = '{4'hF, 1'b0, 4'b0000, 4'b0001, 1'b0, 2'd0, 8'h11};
        vecs[5]  = '{4'hF, 1'b0, 4'b0010, 4'b0000, 1'b1, 2'd1, 8'h22};
        vecs[6]  = '{4'hF, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd1, 8'h22};
        vecs[7]  = '{4'hF, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd1, 8'h22};
        vecs[8]  = '{4'hF, 1'b0, 4'b0000, 4'b0010, 1'b0, 2'd1, 8'h22};
        vecs[9]  = '{4'hF, 1'b0, 4'b0100, 4'b0000, 1'b1, 2'd2, 8'h33};
        vecs[10] = '{4'hF, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2, 8'h33};
        vecs[11] = '{4'hF, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2, 8'h33};
        vecs[12] = '{4'hF, 1'b0, 4'b0000, 4'b0100, 1'b0, 2'd2, 8'h33};
        vecs[13] = '{4'hF, 1'b0, 4'b1000, 4'b0000, 1'b1, 2'd3, 8'h44};
        vecs[14] = '{4'hF, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd3, 8'h44};
        vecs[15] = '{4'hF, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd3, 8'h44};
        vecs[16] = '{4'hF, 1'b0, 4'b0000, 4'b1000, 1'b0, 2'd3, 8'h44};
        vecs[17] = '{4'hF, 1'b0, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'h11};
        vecs[18] = '{4'h0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h11};
        vecs[19] = '{4'h0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h11};
        vecs[20] = '{4'h0, 1'b0, 4'b0000, 4'b0001, 1'b0, 2'd0, 8'h11};

        // Reset with every requester valid.
        resetN   = 1'b0;
        reqValid = 4'hF;
        reqData  = 32'h44332211;
        txBusy   = 1'b0;
        repeat (3) cycle();
        check("rst_ready", 32'(reqReady), 32'd0);
        check("rst_done", 32'(reqDone), 32'd0);
        check("rst_en", 32'(txEnable), 32'd0);
        check("rst_data", 32'(txData), 32'd0);
        check("rst_grant", 32'(grantIdx), 32'd0);
        check("rst_clken", 32'(txClkEn), 32'd0);

        // Divider: tick after edges 3, 7, 11, 15, 19 following release.
        reqValid = 4'h0;
        resetN   = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            cycle();
            check($sformatf("div_c%0d", c), 32'(txClkEn), ((c % 4) == 3) ? 32'd1 : 32'd0);
        end

        for (int i = 0; i < 21; i++) begin
            reqValid = vecs[i].valid;
            txBusy   = vecs[i].busy;
            cycle();
            check($sformatf("v%0d_ready", i), 32'(reqReady), 32'(vecs[i].ready));
            check($sformatf("v%0d_done", i), 32'(reqDone), 32'(vecs[i].done));
            check($sformatf("v%0d_en", i), 32'(txEnable), 32'(vecs[i].en));
            check($sformatf("v%0d_grant", i), 32'(grantIdx), 32'(vecs[i].grant));
            check($sformatf("v%0d_data", i), 32'(txData), 32'(vecs[i].data));
        end

        // Single request with a transmitter model: busy from 2 to 11 cycles after txEnable.
        reqData   = 32'h44A52211;
        reqValid  = 4'b0100;
        txBusy    = 1'b0;
        en_k      = -1;
        ready_cnt = 0;
        done_cnt  = 0;
        done_k    = -1;
        data_bad  = 0;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (reqReady == 4'b0100) ready_cnt++;
            if ((reqReady & 4'b1011) != 4'b0000) ready_cnt += 100;
            if (reqDone == 4'b0100) done_cnt++;
            if ((reqDone & 4'b1011) != 4'b0000) done_cnt += 100;
            if (en_k < 0 && txEnable === 1'b1) begin
                en_k     = c;
                reqValid = 4'b0000;
                reqData  = 32'h44002211;
            end
            if (en_k >= 0) begin
                txBusy = ((c - en_k) >= 1) && ((c - en_k) < 11);
                if (done_k < 0 && txData !== 8'hA5) data_bad++;
                if (done_k < 0 && reqDone == 4'b0100) done_k = c - en_k;
            end
        end
        check("single_ready_pulses", 32'(ready_cnt), 32'd1);
        check("single_done_pulses", 32'(done_cnt), 32'd1);
        check("single_data_held", 32'(data_bad), 32'd0);
        check("single_done_lat", 32'(done_k), 32'd12);
        check("single_grant", 32'(grantIdx), 32'd2);
        check("single_data_final", 32'(txData), 32'hA5);

        // Requesters 0 and 3 both held: plain round-robin alternates, pointer now 2.
        reqValid = 4'b1001;
        txBusy   = 1'b0;
`ifdef UART_TX_SCHED_PRIO_EN
        do_txn(0, "prio_a");
        do_txn(0, "prio_b");
        do_txn(0, "prio_c");
        do_txn(0, "prio_d");
`else
        do_txn(3, "prio_a");
        do_txn(0, "prio_b");
        do_txn(3, "prio_c");
        do_txn(0, "prio_d");
`endif

        // Mid-operation reset in WAIT_DONE after a grant to requester 0.
        reqValid = 4'b0001;
        cycle();
        check("mr_en", 32'(txEnable), 32'd1);
        reqValid = 4'b0000;
        txBusy   = 1'b1;
        cycle();
        cycle();
        resetN = 1'b0;
        #1;
        check("mr_ready", 32'(reqReady), 32'd0);
        check("mr_done", 32'(reqDone), 32'd0);
        check("mr_en0", 32'(txEnable), 32'd0);
        check("mr_data", 32'(txData), 32'd0);
        check("mr_grant", 32'(grantIdx), 32'd0);
        check("mr_clken", 32'(txClkEn), 32'd0);
        txBusy = 1'b0;
        @(negedge clk);
        resetN    = 1'b1;
        done_seen = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            cycle();
            done_seen = done_seen | reqDone;
        end
        check("mr_no_done", 32'(done_seen), 32'd0);
        reqValid = 4'hF;
        cycle();
        check("mr_post_en", 32'(txEnable), 32'd1);
        check("mr_post_grant", 32'(grantIdx), 32'd0);
        check("mr_post_ready", 32'(reqReady), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx_sched

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler that shares one UART transmitter among `NUM_REQ` byte requesters and generates the transmitter's baud enable. It sits between the requester blocks and the transmitter. It arbitrates round-robin, latches the winning byte, and pulses the transmitter's `enable`. It then tracks the transmitter's `busy` to detect completion and returns a per-requester completion pulse.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8
- `CLK_DIV`, 434: clock cycles per baud tick, at least 2

Ports:
- `clk`  in  1  system clock
- `resetN`  in  1  asynchronous reset, active-low
- `reqValid`  in  NUM_REQ  requester i holds a byte for transmission
- `reqData`  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i]
- `reqReady`  out  NUM_REQ  one-cycle pulse when requester i's byte is latched
- `reqDone`  out  NUM_REQ  one-cycle pulse when requester i's byte has finished transmitting
- `txEnable`  out  1  start pulse to the transmitter
- `txData`  out  8  byte to the transmitter, stable from `txEnable` until completion
- `txClkEn`  out  1  baud tick to the transmitter
- `txBusy`  in  1  transmitter busy flag
- `grantIdx`  out  $clog2(NUM_REQ)  index of the current or last granted requester

## Operation
- All outputs are registered.
- Reset values:
  - `reqReady`, `reqDone`, `txEnable`, `txData`, `grantIdx`, `txClkEn` are all 0.
  - State is IDLE.
  - The round-robin pointer is `NUM_REQ-1`, so requester 0 has first priority.
  - The divider count is 0.
- Baud divider:
  - The counter runs 0..`CLK_DIV-1` and wraps.
  - `txClkEn` is 1 for exactly one cycle when the count equals `CLK_DIV-1`.
  - The divider runs freely in every state and is independent of arbitration.
- FSM states:
  - IDLE: if any `reqValid` is set and `txBusy` is 0, select the winner.
    - Search order starts at pointer+1 and wraps modulo `NUM_REQ`.
    - Latch `reqData` slice into `txData`.
    - Set `grantIdx` and the pointer to the winner.
    - Pulse `reqReady[winner]` and `txEnable` for one cycle.
    - Go to WAIT_BUSY.
  - WAIT_BUSY: `txEnable` is 0. When `txBusy` is 1, go to WAIT_DONE.
  - WAIT_DONE: when `txBusy` returns to 0, pulse `reqDone[grantIdx]` for one cycle and go to IDLE.
- At most one bit of `reqReady` and of `reqDone` is set in any cycle.
- `reqValid` deasserting after grant has no effect: the byte is already latched.
- A requester whose `reqValid` is still set in IDLE after its `reqDone` competes again, and only after all others in round-robin order.
- `txBusy` already 1 in IDLE: no grant is made until it clears.
- `reqData` is sampled only in the grant cycle.

## Timing
- Grant latency: `reqValid` sampled in IDLE at edge N gives `txEnable`, `reqReady`, and `txData` valid after edge N.
- Completion: `reqDone` rises the cycle after the first sampled `txBusy`=0 in WAIT_DONE.
- Back-to-back: the next grant occurs no earlier than the cycle after `reqDone`, because IDLE takes one evaluation cycle.
- Reset asserted mid-operation:
  - All outputs go to reset values immediately.
  - Pending `reqDone` is lost.
  - The transmitter itself is not reset by this block.
- Divider wrap: the count goes `CLK_DIV-1` to 0 with no skipped or doubled tick.

## Configuration
- `UART_TX_SCHED_PRIO_EN` defined:
  - Requester 0 has fixed highest priority. Whenever `reqValid[0]` is set in IDLE, it wins.
  - The other requesters use round-robin among themselves.
  - The pointer is updated only on grants to requesters 1..`NUM_REQ-1`.
- Undefined: pure round-robin across all requesters, as described above.

## Structure
- The shared UART package holds the FSM state enum (IDLE, WAIT_BUSY, WAIT_DONE) and the default `CLK_DIV` constant.
- One sub-module, `uart_baud_div`: the free-running divider producing `txClkEn`, parameterised by `CLK_DIV`.
- The arbiter and FSM stay in the top module.

## Test plan
- Reset: hold `resetN`=0 with all `reqValid`=1 -> all outputs 0. After release, the first grant goes to requester 0 with `txData`=`reqData[7:0]`.
- Divider: `CLK_DIV`=4, run 20 cycles -> `txClkEn` high on cycles 3, 7, 11, 15, 19 only.
- Single request: `reqValid[2]`=1 with byte 0xA5, model `txBusy` high 2 cycles after `txEnable` and for 10 cycles -> one `reqReady[2]` pulse, `txData`=0xA5 held, one `reqDone[2]` pulse, `grantIdx`=2.
- Fairness: all four `reqValid` held high -> grant order 0, 1, 2, 3, 0, with no grant while `txBusy`=1.
- Priority, with `UART_TX_SCHED_PRIO_EN` defined: `reqValid[0]` and `reqValid[3]` held -> requester 0 always wins. Without the macro, grants alternate 0, 3.
- Mid-operation reset: assert `resetN`=0 in WAIT_DONE -> `reqDone` never pulses, state is IDLE, pointer is `NUM_REQ-1`.
